// File: rtl/mps_op_sequencer.sv
// MPS power-on/off sequencer: N_STEP DI-check steps plus a DC-link check, and a
// main-off / discharge / system-off sequence. Reports state, step, fail cause.
// Ports: i_clk, i_rst (async, active-low), i_on_req/i_off_req pulses, i_intl
//   level, i_dc_v signed voltage, i_ext_di inputs, i_step_sel/i_step_pol per
//   step, i_hold_cyc hold time; o_on_state, o_step_idx, o_off_state,
//   o_fail_step, o_fail_code, o_sys_on.
// Option: define MPS_SEQ_STEP_MASK_EN to add i_step_en (per-step skip mask).
module mps_op_sequencer #(
  parameter int N_STEP     = 4,
  parameter int DI_W       = 16,
  parameter int HOLD_W     = 28,
  parameter int DC_POS     = 2,
  parameter int DCV_W      = 32,
  parameter int ON_DCV_TH  = 267,
  parameter int OFF_DCV_TH = 10,
  parameter int OFF_HOLD   = 1000,
  parameter int TIMEOUT    = 2000000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_on_req,
  input  logic                    i_off_req,
  input  logic                    i_intl,
  input  logic signed [DCV_W-1:0] i_dc_v,
  input  logic [DI_W-1:0]         i_ext_di,
  input  logic [N_STEP*4-1:0]     i_step_sel,
  input  logic [N_STEP-1:0]       i_step_pol,
`ifdef MPS_SEQ_STEP_MASK_EN
  input  logic [N_STEP-1:0]       i_step_en,
`endif
  input  logic [HOLD_W-1:0]       i_hold_cyc,
  output logic [2:0]              o_on_state,
  output logic [3:0]              o_step_idx,
  output logic [2:0]              o_off_state,
  output logic [4:0]              o_fail_step,
  output logic [2:0]              o_fail_code,
  output logic                    o_sys_on
);

  typedef enum logic [2:0] {
    ON_IDLE = 3'd0, ON_CLR = 3'd1, ON_STEP = 3'd2,
    ON_DC   = 3'd3, ON_SYS = 3'd4, ON_FAIL = 3'd7
  } on_t;

  typedef enum logic [2:0] {
    OF_IDLE = 3'd0, OF_MAIN = 3'd1, OF_DIS = 3'd2,
    OF_SYS  = 3'd3, OF_FAIL = 3'd7
  } off_t;

  localparam logic [30:0] TO_LAST   = 31'(TIMEOUT - 1);
  localparam logic [30:0] HOLD_LAST = 31'(OFF_HOLD - 1);
  localparam logic [4:0]  DCP       = 5'(DC_POS);
  localparam logic [4:0]  NST       = 5'(N_STEP);
  localparam logic signed [DCV_W-1:0] ON_TH  = DCV_W'(ON_DCV_TH);
  localparam logic signed [DCV_W-1:0] OFF_TH = DCV_W'(OFF_DCV_TH);
  localparam logic [HOLD_W-1:0] H_ONE = HOLD_W'(1);

  on_t               on_st, on_nx;
  off_t              off_st, off_nx;
  logic [3:0]        step_idx, idx_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_m1;
  logic [30:0]       step_to, off_to;
  logic              dc_q, dis_q;
  logic [4:0]        fail_step;
  logic [2:0]        fail_code, on_code;
  logic              on_code_wr, enter, clr_go, off_go;
  logic              cond, step_pass;
  logic [4:0]        nxt_i;
  logic [15:0]       di_pad, pol_pad, en_pad;
  logic [3:0]        sel_arr [16];

  // Pad DI and per-step config to 16 entries; unused selects read as 0.
  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < DI_W) begin : g_di
      assign di_pad[g] = i_ext_di[g];
    end else begin : g_nodi
      assign di_pad[g] = 1'b0;
    end
    if (g < N_STEP) begin : g_st
      assign sel_arr[g] = i_step_sel[4*g +: 4];
      assign pol_pad[g] = i_step_pol[g];
`ifdef MPS_SEQ_STEP_MASK_EN
      assign en_pad[g]  = i_step_en[g];
`else
      assign en_pad[g]  = 1'b1;
`endif
    end else begin : g_nost
      assign sel_arr[g] = 4'd0;
      assign pol_pad[g] = 1'b0;
      assign en_pad[g]  = 1'b1;
    end
  end

  assign hold_m1   = (i_hold_cyc == '0) ? '0 : i_hold_cyc - H_ONE;
  assign cond      = di_pad[sel_arr[step_idx]] == pol_pad[step_idx];
  assign step_pass = cond && (hold_cnt == hold_m1);
  assign nxt_i     = {1'b0, step_idx} + 5'd1;
  assign off_go    = (off_st == OF_IDLE) && i_off_req;
  assign clr_go    = (on_st == ON_IDLE) && i_on_req && !i_intl &&
                     (off_st == OF_IDLE) && !i_off_req;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      on_st  <= ON_IDLE;
      off_st <= OF_IDLE;
    end else begin
      on_st  <= on_nx;
      off_st <= off_nx;
    end
  end

  // On-sequence: interlock beats abort, abort beats pass, pass beats timeout.
  always_comb begin
    on_nx      = on_st;
    idx_nx     = step_idx;
    on_code    = 3'd0;
    on_code_wr = 1'b0;
    unique case (on_st)
      ON_IDLE: if (clr_go) on_nx = ON_CLR;
      ON_CLR, ON_STEP, ON_DC: begin
        if (i_intl) begin
          on_nx      = ON_FAIL;
          on_code    = 3'd1;
          on_code_wr = 1'b1;
        end else if (off_go) begin
          on_nx      = ON_IDLE;
          on_code    = 3'd4;
          on_code_wr = 1'b1;
        end else if (on_st == ON_CLR) begin
          if (DCP == 5'd0) on_nx = ON_DC;
          else begin
            on_nx  = ON_STEP;
            idx_nx = 4'd0;
          end
        end else if (on_st == ON_STEP &&
                     (!en_pad[step_idx] || step_pass)) begin
          if (nxt_i == DCP) on_nx = ON_DC;
          else if (nxt_i == NST) on_nx = ON_SYS;
          else begin
            on_nx  = ON_STEP;
            idx_nx = nxt_i[3:0];
          end
        end else if (on_st == ON_DC && dc_q) begin
          if (DCP == NST) on_nx = ON_SYS;
          else begin
            on_nx  = ON_STEP;
            idx_nx = DCP[3:0];
          end
        end else if (step_to == TO_LAST) begin
          on_nx      = ON_FAIL;
          on_code    = 3'd2;
          on_code_wr = 1'b1;
        end
      end
      ON_SYS: begin
        if (i_intl) begin
          on_nx      = ON_FAIL;
          on_code    = 3'd1;
          on_code_wr = 1'b1;
        end else if (off_st == OF_SYS) begin
          on_nx = ON_IDLE;
        end
      end
      default: on_nx = ON_IDLE;
    endcase
  end

  always_comb begin
    off_nx = off_st;
    unique case (off_st)
      OF_IDLE: if (i_off_req) off_nx = OF_MAIN;
      OF_MAIN: begin
        if (off_to == TO_LAST) off_nx = OF_FAIL;
        else if (off_to == HOLD_LAST) off_nx = OF_DIS;
      end
      OF_DIS: begin
        if (off_to == TO_LAST) off_nx = OF_FAIL;
        else if (dis_q) off_nx = OF_SYS;
      end
      default: off_nx = OF_IDLE;
    endcase
  end

  // New step or DC check (including step-to-step moves).
  assign enter = ((on_nx == ON_STEP) || (on_nx == ON_DC)) &&
                 ((on_nx != on_st) || (idx_nx != step_idx));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      step_idx  <= 4'd0;
      hold_cnt  <= '0;
      step_to   <= 31'd0;
      off_to    <= 31'd0;
      dc_q      <= 1'b0;
      dis_q     <= 1'b0;
      fail_step <= 5'd0;
      fail_code <= 3'd0;
    end else begin
      step_idx <= idx_nx;
      // Voltage compares only qualify while in their own state.
      dc_q  <= (on_st == ON_DC) && (i_dc_v > ON_TH);
      dis_q <= (off_st == OF_DIS) && (i_dc_v < OFF_TH);
      if (enter) begin
        hold_cnt <= '0;
        step_to  <= 31'd0;
      end else begin
        hold_cnt <= (on_st == ON_STEP && cond) ? hold_cnt + H_ONE : '0;
        step_to  <= (on_st == ON_STEP || on_st == ON_DC) ?
                    step_to + 31'd1 : 31'd0;
      end
      off_to <= (off_st == OF_IDLE) ? 31'd0 : off_to + 31'd1;
      if (clr_go) begin
        fail_step <= 5'd0;
        fail_code <= 3'd0;
      end else begin
        if (enter)
          fail_step <= (on_nx == ON_DC) ? 5'd16 : {1'b0, idx_nx};
        if (on_code_wr)
          fail_code <= on_code;
        else if (off_nx == OF_FAIL && off_st != OF_FAIL)
          fail_code <= 3'd3;
      end
    end
  end

  always_comb begin
    o_on_state  = on_st;
    o_step_idx  = step_idx;
    o_off_state = off_st;
    o_fail_step = fail_step;
    o_fail_code = fail_code;
    o_sys_on    = (on_st == ON_SYS);
  end

endmodule

// File: tb/tb_mps_op_sequencer.sv
// Directed self-checking bench for mps_op_sequencer.
// N_STEP=4, DC_POS=2, TIMEOUT=1000, OFF_HOLD=8.
module tb_mps_op_sequencer;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_on_req;
  logic               i_off_req;
  logic               i_intl;
  logic signed [31:0] i_dc_v;
  logic [15:0]        i_ext_di;
  logic [15:0]        i_step_sel;
  logic [3:0]         i_step_pol;
`ifdef MPS_SEQ_STEP_MASK_EN
  logic [3:0]         i_step_en;
`endif
  logic [27:0]        i_hold_cyc;
  logic [2:0]         o_on_state;
  logic [3:0]         o_step_idx;
  logic [2:0]         o_off_state;
  logic [4:0]         o_fail_step;
  logic [2:0]         o_fail_code;
  logic               o_sys_on;

  // step0 bit1=1, step1 bit5=0, step2 bit9=1, step3 bit12=0
  localparam logic [15:0] DI_OK = 16'h0202;

  int total = 0;
  int bad = 0;

  mps_op_sequencer #(.TIMEOUT(1000), .OFF_HOLD(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_on_req(i_on_req), .i_off_req(i_off_req),
    .i_intl(i_intl), .i_dc_v(i_dc_v), .i_ext_di(i_ext_di),
    .i_step_sel(i_step_sel), .i_step_pol(i_step_pol),
`ifdef MPS_SEQ_STEP_MASK_EN
    .i_step_en(i_step_en),
`endif
    .i_hold_cyc(i_hold_cyc),
    .o_on_state(o_on_state), .o_step_idx(o_step_idx),
    .o_off_state(o_off_state), .o_fail_step(o_fail_step),
    .o_fail_code(o_fail_code), .o_sys_on(o_sys_on)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_on();
    i_on_req = 1'b1;
    tick(1);
    i_on_req = 1'b0;
  endtask

  task automatic pulse_off();
    i_off_req = 1'b1;
    tick(1);
    i_off_req = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_on_req = 1'b0;
    i_off_req = 1'b0;
    i_intl = 1'b0;
    i_dc_v = 300;
    i_ext_di = DI_OK;
    i_step_sel = {4'd12, 4'd9, 4'd5, 4'd1};
    i_step_pol = 4'b0101;
`ifdef MPS_SEQ_STEP_MASK_EN
    i_step_en = 4'hF;
`endif
    i_hold_cyc = 28'd4;
    tick(2);
    total++;
    if ({o_on_state, o_off_state, o_step_idx, o_fail_step,
         o_fail_code, o_sys_on} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0",
        {o_on_state, o_off_state, o_step_idx, o_fail_step,
         o_fail_code, o_sys_on});
    end
    i_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_nominal();
    int n;
    int n_dc;
    i_hold_cyc = 28'd4;
    i_ext_di = DI_OK;
    i_dc_v = 300;
    pulse_on();
    total++;
    if (o_on_state !== 3'd1) begin
      bad++;
      $display("FAIL nom_clr got=%0d want=1", o_on_state);
    end
    n = 0;
    n_dc = -1;
    while (!o_sys_on && n < 100) begin
      tick(1);
      n++;
      if (o_on_state == 3'd3 && n_dc < 0) n_dc = n;
      if (n == 5) begin
        total++;
        if ({o_on_state, o_step_idx} !== {3'd2, 4'd1}) begin
          bad++;
          $display("FAIL nom_step1 got=%0d/%0d want=2/1",
            o_on_state, o_step_idx);
        end
      end
    end
    total++;
    if (n !== 19) begin
      bad++;
      $display("FAIL nom_sys_on_lat got=%0d want=19", n);
    end
    total++;
    if (n_dc !== 9) begin
      bad++;
      $display("FAIL nom_dc_entry got=%0d want=9", n_dc);
    end
    total++;
    if ({o_fail_code, o_fail_step} !== {3'd0, 5'd3}) begin
      bad++;
      $display("FAIL nom_fail_info got=%0d/%0d want=0/3",
        o_fail_code, o_fail_step);
    end
  endtask

  task automatic test_off_ok();
    pulse_off();
    total++;
    if ({o_off_state, o_on_state} !== {3'd1, 3'd4}) begin
      bad++;
      $display("FAIL off_main got=%0d/%0d want=1/4", o_off_state, o_on_state);
    end
    tick(7);
    total++;
    if (o_off_state !== 3'd1) begin
      bad++;
      $display("FAIL off_main_end got=%0d want=1", o_off_state);
    end
    tick(1);
    total++;
    if (o_off_state !== 3'd2) begin
      bad++;
      $display("FAIL off_discha got=%0d want=2", o_off_state);
    end
    tick(12);
    i_dc_v = 5;
    tick(1);
    total++;
    if (o_off_state !== 3'd2) begin
      bad++;
      $display("FAIL off_dis_reg got=%0d want=2", o_off_state);
    end
    tick(1);
    total++;
    if ({o_off_state, o_on_state} !== {3'd3, 3'd4}) begin
      bad++;
      $display("FAIL off_sysoff got=%0d/%0d want=3/4",
        o_off_state, o_on_state);
    end
    tick(1);
    total++;
    if ({o_off_state, o_on_state, o_sys_on} !== 7'd0) begin
      bad++;
      $display("FAIL off_idle got=%0d/%0d/%0d want=0/0/0",
        o_off_state, o_on_state, o_sys_on);
    end
    i_dc_v = 300;
  endtask

  task automatic test_hold_zero();
    int n;
    i_hold_cyc = 28'd0;
    pulse_on();
    n = 0;
    while (!o_sys_on && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (n !== 7) begin
      bad++;
      $display("FAIL hold0_lat got=%0d want=7", n);
    end
    i_intl = 1'b1;
    tick(1);
    i_intl = 1'b0;
    total++;
    if ({o_on_state, o_fail_code, o_fail_step} !== {3'd7, 3'd1, 5'd3}) begin
      bad++;
      $display("FAIL hold0_intl got=%0d/%0d/%0d want=7/1/3",
        o_on_state, o_fail_code, o_fail_step);
    end
    tick(1);
    total++;
    if (o_on_state !== 3'd0) begin
      bad++;
      $display("FAIL hold0_idle got=%0d want=0", o_on_state);
    end
    i_hold_cyc = 28'd4;
  endtask

  task automatic test_glitch();
    i_hold_cyc = 28'd8;
    pulse_on();
    tick(14);
    total++;
    if ({o_on_state, o_step_idx} !== {3'd2, 4'd1}) begin
      bad++;
      $display("FAIL gl_pre got=%0d/%0d want=2/1", o_on_state, o_step_idx);
    end
    i_ext_di = DI_OK | 16'h0020;
    tick(1);
    i_ext_di = DI_OK;
    tick(7);
    total++;
    if ({o_on_state, o_step_idx} !== {3'd2, 4'd1}) begin
      bad++;
      $display("FAIL gl_hold got=%0d/%0d want=2/1", o_on_state, o_step_idx);
    end
    tick(1);
    total++;
    if ({o_on_state, o_fail_step} !== {3'd3, 5'd16}) begin
      bad++;
      $display("FAIL gl_dc got=%0d/%0d want=3/16", o_on_state, o_fail_step);
    end
    i_intl = 1'b1;
    tick(1);
    i_intl = 1'b0;
    total++;
    if ({o_on_state, o_fail_code} !== {3'd7, 3'd1}) begin
      bad++;
      $display("FAIL gl_dc_intl got=%0d/%0d want=7/1", o_on_state, o_fail_code);
    end
    tick(1);
    i_hold_cyc = 28'd4;
  endtask

  task automatic test_timeout();
    i_ext_di = DI_OK & ~16'h0200;
    pulse_on();
    tick(11);
    total++;
    if ({o_on_state, o_step_idx, o_fail_step} !== {3'd2, 4'd2, 5'd2}) begin
      bad++;
      $display("FAIL to_entry got=%0d/%0d/%0d want=2/2/2",
        o_on_state, o_step_idx, o_fail_step);
    end
    tick(999);
    total++;
    if (o_on_state !== 3'd2) begin
      bad++;
      $display("FAIL to_before got=%0d want=2", o_on_state);
    end
    tick(1);
    total++;
    if ({o_on_state, o_fail_code, o_fail_step} !== {3'd7, 3'd2, 5'd2}) begin
      bad++;
      $display("FAIL to_fail got=%0d/%0d/%0d want=7/2/2",
        o_on_state, o_fail_code, o_fail_step);
    end
    tick(1);
    total++;
    if ({o_on_state, o_fail_code} !== {3'd0, 3'd2}) begin
      bad++;
      $display("FAIL to_idle got=%0d/%0d want=0/2", o_on_state, o_fail_code);
    end
    i_ext_di = DI_OK;
  endtask

  task automatic test_interlock();
    pulse_on();
    tick(6);
    i_intl = 1'b1;
    tick(1);
    total++;
    if ({o_on_state, o_fail_code, o_fail_step} !== {3'd7, 3'd1, 5'd1}) begin
      bad++;
      $display("FAIL il_fail got=%0d/%0d/%0d want=7/1/1",
        o_on_state, o_fail_code, o_fail_step);
    end
    tick(1);
    pulse_on();
    tick(1);
    total++;
    if ({o_on_state, o_fail_code} !== {3'd0, 3'd1}) begin
      bad++;
      $display("FAIL il_block got=%0d/%0d want=0/1", o_on_state, o_fail_code);
    end
    i_intl = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    pulse_on();
    tick(6);
    pulse_off();
    total++;
    if ({o_on_state, o_off_state, o_fail_code, o_fail_step} !==
        {3'd0, 3'd1, 3'd4, 5'd1}) begin
      bad++;
      $display("FAIL ab_abort got=%0d/%0d/%0d/%0d want=0/1/4/1",
        o_on_state, o_off_state, o_fail_code, o_fail_step);
    end
    pulse_on();
    total++;
    if (o_on_state !== 3'd0) begin
      bad++;
      $display("FAIL ab_on_ignored got=%0d want=0", o_on_state);
    end
    i_dc_v = 5;
    n = 0;
    while (o_off_state != 3'd0 && n < 40) begin
      tick(1);
      n++;
    end
    total++;
    if ({o_off_state, o_on_state, o_fail_code} !== {3'd0, 3'd0, 3'd4}) begin
      bad++;
      $display("FAIL ab_off_done got=%0d/%0d/%0d want=0/0/4",
        o_off_state, o_on_state, o_fail_code);
    end
    i_dc_v = 300;
  endtask

  task automatic test_simultaneous();
    int n;
    i_on_req = 1'b1;
    i_off_req = 1'b1;
    tick(1);
    i_on_req = 1'b0;
    i_off_req = 1'b0;
    total++;
    if ({o_on_state, o_off_state} !== {3'd0, 3'd1}) begin
      bad++;
      $display("FAIL sim_off_wins got=%0d/%0d want=0/1",
        o_on_state, o_off_state);
    end
    i_dc_v = 5;
    n = 0;
    while (o_off_state != 3'd0 && n < 40) begin
      tick(1);
      n++;
    end
    i_dc_v = 300;
  endtask

`ifdef MPS_SEQ_STEP_MASK_EN
  task automatic test_mask();
    i_step_en = 4'b1011;
    pulse_on();
    tick(11);
    tick(1);
    total++;
    if ({o_on_state, o_step_idx, o_fail_step} !== {3'd2, 4'd3, 5'd3}) begin
      bad++;
      $display("FAIL mask_skip got=%0d/%0d/%0d want=2/3/3",
        o_on_state, o_step_idx, o_fail_step);
    end
    tick(4);
    total++;
    if (o_sys_on !== 1'b1) begin
      bad++;
      $display("FAIL mask_sys_on got=%0d want=1", o_sys_on);
    end
    i_step_en = 4'hF;
    i_intl = 1'b1;
    tick(1);
    i_intl = 1'b0;
    tick(1);
  endtask
`endif

  task automatic test_off_fail();
    pulse_on();
    tick(19);
    total++;
    if (o_sys_on !== 1'b1) begin
      bad++;
      $display("FAIL of_sys_on got=%0d want=1", o_sys_on);
    end
    pulse_off();
    tick(999);
    total++;
    if (o_off_state !== 3'd2) begin
      bad++;
      $display("FAIL of_before got=%0d want=2", o_off_state);
    end
    tick(1);
    total++;
    if ({o_off_state, o_fail_code, o_on_state} !== {3'd7, 3'd3, 3'd4}) begin
      bad++;
      $display("FAIL of_fail got=%0d/%0d/%0d want=7/3/4",
        o_off_state, o_fail_code, o_on_state);
    end
    tick(1);
    total++;
    if ({o_off_state, o_on_state} !== {3'd0, 3'd4}) begin
      bad++;
      $display("FAIL of_idle got=%0d/%0d want=0/4", o_off_state, o_on_state);
    end
  endtask

  task automatic test_reset_mid();
    i_rst = 1'b0;
    #1;
    total++;
    if ({o_on_state, o_off_state, o_step_idx, o_fail_step,
         o_fail_code, o_sys_on} !== 19'd0) begin
      bad++;
      $display("FAIL rst_async got=%h want=0",
        {o_on_state, o_off_state, o_step_idx, o_fail_step,
         o_fail_code, o_sys_on});
    end
    #2;
    i_rst = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_off_ok();
    test_hold_zero();
    test_glitch();
    test_timeout();
    test_interlock();
    test_abort();
    test_simultaneous();
`ifdef MPS_SEQ_STEP_MASK_EN
    test_mask();
`endif
    test_off_fail();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
